// File: rtl/seq_ab_gen.sv
// seq_ab_gen
//   Stimulus generator for the "a then b" handshake. A start command in IDLE
//   emits a one-cycle pulse on a, waits a programmable gap, then holds b for
//   a programmable number of cycles. The a/b pattern repeats for a
//   programmable iteration count and finishes with a one-cycle done pulse.
//
//   Optional build macro: SEQ_AB_GEN_ERRINJ_EN
//     When defined, inj_err sampled while a is high suppresses b for the
//     whole B phase of that iteration (timing and counters unchanged), which
//     produces a deliberate a ##1 !b violation. When undefined, inj_err is
//     ignored and b is always driven normally.
//
// Ports
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   start     in   begin a run (sampled only in IDLE)
//   gap       in   extra cycles between a and b (latched on start)
//   hold      in   b high duration, 0 treated as 1 (latched on start)
//   reps      in   iterations per run, 0 treated as 1 (latched on start)
//   inj_err   in   error-injection request (see macro above)
//   a         out  registered pulse
//   b         out  registered level
//   busy      out  high from the cycle after start until done
//   done      out  one-cycle completion pulse
//   iter_cnt  out  completed iterations in the current or last run
module seq_ab_gen #(
  parameter int GAP_W  = 4,
  parameter int HOLD_W = 4,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap,
  input  logic [HOLD_W-1:0] hold,
  input  logic [REP_W-1:0]  reps,
  input  logic              inj_err,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A,
    S_GAP,
    S_B,
    S_FIN
  } state_t;

  state_t            state;
  logic [GAP_W-1:0]  gap_q;
  logic [HOLD_W-1:0] hold_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  reps_left;
  logic              inj_q;
  logic              inj_a;

`ifdef SEQ_AB_GEN_ERRINJ_EN
  assign inj_a = inj_err;
`else
  logic unused_inj_err;
  assign unused_inj_err = inj_err;
  assign inj_a = 1'b0;
`endif

  function automatic logic [HOLD_W-1:0] hold_floor(input logic [HOLD_W-1:0] v);
    return (v == '0) ? HOLD_W'(1) : v;
  endfunction

  function automatic logic [REP_W-1:0] reps_floor(input logic [REP_W-1:0] v);
    return (v == '0) ? REP_W'(1) : v;
  endfunction

  function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
    return (v == '1) ? v : v + REP_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gap_q     <= '0;
      hold_q    <= '0;
      gap_cnt   <= '0;
      hold_cnt  <= '0;
      reps_left <= '0;
      inj_q     <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      iter_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            gap_q     <= gap;
            hold_q    <= hold_floor(hold);
            reps_left <= reps_floor(reps);
            iter_cnt  <= '0;
            inj_q     <= 1'b0;
            a         <= 1'b1;
            busy      <= 1'b1;
            state     <= S_A;
          end
        end
        S_A: begin
          // inj_err is captured while a is high and governs this iteration's B phase.
          a        <= 1'b0;
          inj_q    <= inj_a;
          hold_cnt <= hold_q;
          if (gap_q != '0) begin
            gap_cnt <= gap_q;
            state   <= S_GAP;
          end else begin
            b     <= ~inj_a;
            state <= S_B;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            b     <= ~inj_q;
            state <= S_B;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_B: begin
          if (hold_cnt == HOLD_W'(1)) begin
            b        <= 1'b0;
            iter_cnt <= sat_inc(iter_cnt);
            // reps_left counts iterations still owed including this one.
            if (reps_left > REP_W'(1)) begin
              reps_left <= reps_left - REP_W'(1);
              a         <= 1'b1;
              state     <= S_A;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ab_gen.sv
// tb_seq_ab_gen
//   Randomized and directed bench for seq_ab_gen. A timeline model expands
//   each accepted run into its expected per-cycle output sequence; a compare
//   process checks every output on every cycle. Directed scenarios pin the
//   model with hand-computed literal expectations.
module tb_seq_ab_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] gap;
  logic [3:0] hold;
  logic [7:0] reps;
  logic       inj_err;
  logic       a, b, busy, done;
  logic [7:0] iter_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  seq_ab_gen #(.GAP_W(4), .HOLD_W(4), .REP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .gap(gap), .hold(hold), .reps(reps),
    .inj_err(inj_err), .a(a), .b(b), .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [7:0] it;
  } out_t;

  out_t q[$];
  out_t exp_o = '0;
  logic kill_b = 1'b0;
  logic started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Expand one run into its cycle-by-cycle expected outputs.
  task automatic build_run(input int g, input int h, input int r);
    int rr, hh;
    rr = (r == 0) ? 1 : r;
    hh = (h == 0) ? 1 : h;
    for (int i = 0; i < rr; i++) begin
      q.push_back('{a:1'b1, b:1'b0, busy:1'b1, done:1'b0, it:8'(i)});
      for (int k = 0; k < g; k++)
        q.push_back('{a:1'b0, b:1'b0, busy:1'b1, done:1'b0, it:8'(i)});
      for (int k = 0; k < hh; k++)
        q.push_back('{a:1'b0, b:1'b1, busy:1'b1, done:1'b0, it:8'(i)});
    end
    q.push_back('{a:1'b0, b:1'b0, busy:1'b0, done:1'b1, it:8'(rr)});
  endtask

  // Reference model: next expected outputs after each edge.
  always @(posedge clk) begin
    out_t nxt;
    started <= 1'b1;
    if (rst) begin
      q.delete();
      exp_o  = '0;
      kill_b = 1'b0;
    end else begin
      if (q.size() == 0 && !exp_o.done && start) begin
        build_run(int'(gap), int'(hold), int'(reps));
        kill_b = 1'b0;
      end
`ifdef SEQ_AB_GEN_ERRINJ_EN
      if (exp_o.a) kill_b = inj_err;
`endif
      if (q.size() > 0) begin
        nxt = q.pop_front();
        if (kill_b) nxt.b = 1'b0;
        exp_o = nxt;
      end else begin
        exp_o = '{a:1'b0, b:1'b0, busy:1'b0, done:1'b0, it:exp_o.it};
      end
    end
  end

  // Compare process plus a simple a ##1 b violation counter.
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("model_a", a, exp_o.a);
      chk("model_b", b, exp_o.b);
      chk("model_busy", busy, exp_o.busy);
      chk("model_done", done, exp_o.done);
      chk("model_iter", iter_cnt, exp_o.it);
      chk("a_b_exclusive", a & b, 0);
      if (prev_a && !b) viol++;
      prev_a = a;
    end
  end

  task automatic do_start(input logic [3:0] g, input logic [3:0] h, input logic [7:0] r);
    gap   = g;
    hold  = h;
    reps  = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    bit seen;
    rst = 1'b1; start = 1'b0; gap = '0; hold = '0; reps = '0; inj_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Reset and idle.
    for (int t = 0; t < 10; t++) begin
      chk("idle_outputs", {a, b, busy, done, iter_cnt}, 0);
      @(negedge clk);
    end

    // Basic run: gap 0, hold 1, reps 1.
    do_start(4'd0, 4'd1, 8'd1);
    chk("basic_a", a, 1); chk("basic_busy0", busy, 1); chk("basic_b0", b, 0);
    @(negedge clk);
    chk("basic_b", b, 1); chk("basic_a_low", a, 0); chk("basic_busy1", busy, 1);
    @(negedge clk);
    chk("basic_done", done, 1); chk("basic_busy_low", busy, 0); chk("basic_iter", iter_cnt, 1);
    @(negedge clk);
    chk("basic_done_pulse", done, 0); chk("basic_iter_hold", iter_cnt, 1);

    // Gap 2, hold 3, reps 2.
    do_start(4'd2, 4'd3, 8'd2);
    for (int t = 0; t < 14; t++) begin
      chk("ghr_a", a, (t == 0 || t == 6));
      chk("ghr_b", b, ((t >= 3 && t <= 5) || (t >= 9 && t <= 11)));
      chk("ghr_done", done, (t == 12));
      chk("ghr_busy", busy, (t < 12));
      if (t >= 12) chk("ghr_iter", iter_cnt, 2);
      @(negedge clk);
    end

    // Zero fields and ignored restarts while busy / in FIN.
    do_start(4'd1, 4'd0, 8'd0);
    dcount = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) dcount++;
      chk("zero_a", a, (t == 0));
      chk("zero_b", b, (t == 2));
      chk("zero_done", done, (t == 3));
      start = (t >= 1 && t <= 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("zero_done_count", dcount, 1);

    // Mid-run reset during the second GAP.
    do_start(4'd5, 4'd4, 8'd3);
    for (int t = 0; t <= 12; t++) begin
      chk("mid_a", a, (t == 0 || t == 10));
      chk("mid_b", b, (t >= 6 && t <= 9));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_outputs", {a, b, busy, done, iter_cnt}, 0);
    dcount = 0;
    for (int t = 0; t < 20; t++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("mid_no_done", dcount, 0);
    do_start(4'd0, 4'd1, 8'd2);
    chk("restart_iter0", iter_cnt, 0); chk("restart_a", a, 1);
    repeat (2) @(negedge clk);
    chk("restart_iter1", iter_cnt, 1); chk("restart_a2", a, 1);
    repeat (2) @(negedge clk);
    chk("restart_done", done, 1); chk("restart_iter2", iter_cnt, 2);
    @(negedge clk);

    // Error injection on the second a pulse.
    viol = 0;
    do_start(4'd0, 4'd1, 8'd3);
    for (int t = 0; t < 8; t++) begin
      inj_err = (t == 2);
`ifdef SEQ_AB_GEN_ERRINJ_EN
      chk("inj_b", b, (t == 1 || t == 5));
`else
      chk("inj_b", b, (t == 1 || t == 3 || t == 5));
`endif
      chk("inj_done", done, (t == 6));
      @(negedge clk);
    end
    inj_err = 1'b0;
`ifdef SEQ_AB_GEN_ERRINJ_EN
    chk("inj_violations", viol, 1);
`else
    chk("inj_violations", viol, 0);
`endif

    // Long run up to the full repeat field.
    do_start(4'd0, 4'd0, 8'd255);
    seen = 1'b0;
    for (int t = 0; t < 600 && !seen; t++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("long_done_seen", seen, 1);
    chk("long_iter", iter_cnt, 255);
    @(negedge clk);

    // Randomized stimulus, including mid-run field changes and resets.
    for (int t = 0; t < 4000; t++) begin
      rst     = ($urandom % 400) == 0;
      start   = ($urandom % 6) == 0;
      gap     = 4'($urandom);
      hold    = 4'($urandom);
      reps    = 8'($urandom_range(0, 4));
      inj_err = $urandom % 2;
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; inj_err = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
